// File: rtl/bw_pkg.sv
// Shared definitions for the Baugh-Wooley multiplier slice: sequencer
// state encoding, default operand width and the correction constant that
// the adder array adds to the weighted row sum.
package bw_pkg;

  localparam int unsigned BW_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // 2^width + 2^(2*width-1), returned at full 64-bit width; callers slice
  // it down to 2*width bits.
  function automatic logic [63:0] bw_corr(input int unsigned width);
    return (64'd1 << width) | (64'd1 << (2 * width - 1));
  endfunction

endpackage

// File: rtl/bw_pp_row.sv
// One Baugh-Wooley partial-product row (combinational).
//   a_i    multiplicand A
//   b_i    multiplier B
//   idx_i  row index i
//   row_o  A & B[i] with the sign-term complements applied
module bw_pp_row #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [IDXW-1:0]  idx_i,
  output logic [WIDTH-1:0] row_o
);

  localparam logic [IDXW-1:0]  LAST = IDXW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] ands;

  // Ordinary rows complement only the A[N-1] term; the sign row (B[N-1])
  // complements every term except A[N-1]&B[N-1].
  always_comb begin
    ands  = a_i & {WIDTH{b_i[idx_i]}};
    row_o = ands ^ ((idx_i == LAST) ? ~MSB : MSB);
  end

endmodule

// File: rtl/bw_pp_sequencer.sv
// Sequential Baugh-Wooley partial-product front end. Accepts one signed
// operand pair, then emits WIDTH rows (index ascending) one per handshake.
//   clk_in, rst_n_in          clock, async active-low reset
//   a_in, b_in, in_valid_in,  operand pair handshake (in_ready_out)
//   row_out, row_idx_out,     current row, its weight index and last flag,
//   row_last_out              forced to 0 while row_valid_out is low
//   row_valid_out, row_ready_in  row handshake
//   corr_out                  constant correction 2^W + 2^(2W-1)
module bw_pp_sequencer
  import bw_pkg::*;
#(
  parameter  int unsigned WIDTH = BW_WIDTH,
  localparam int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               in_valid_in,
  output logic               in_ready_out,
  output logic [WIDTH-1:0]   row_out,
  output logic [IDXW-1:0]    row_idx_out,
  output logic               row_last_out,
  output logic               row_valid_out,
  input  logic               row_ready_in,
  output logic [2*WIDTH-1:0] corr_out
);

  localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);
  localparam logic [63:0]     CORR = bw_corr(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] row_w;
  logic             emit;

  bw_pp_row #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_row (
    .a_i   (a_q),
    .b_i   (b_q),
    .idx_i (idx_q),
    .row_o (row_w)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_in) begin
          state_d = EMIT;
          a_d     = a_in;
          b_d     = b_in;
          idx_d   = '0;
        end
      end
      EMIT: begin
        if (row_ready_in) begin
          if (idx_q == LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs derive from registered state only.
  always_comb begin
    emit          = (state_q == EMIT);
    in_ready_out  = !emit;
    row_valid_out = emit;
    row_out       = emit ? row_w : '0;
    row_idx_out   = emit ? idx_q : '0;
    row_last_out  = emit && (idx_q == LAST);
  end

  assign corr_out = CORR[2*WIDTH-1:0];

endmodule

// File: tb/tb_bw_pp_sequencer.sv
// Bench for bw_pp_sequencer: a WIDTH=4 instance for the directed cases and
// a WIDTH=8 instance for randomized operands with random backpressure.
module tb_bw_pp_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          sel;
  logic [63:0] drv_a, drv_b;
  logic        drv_valid, drv_rrdy;
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] row4;  logic [1:0] idx4;  logic rdy4, vld4, last4;  logic [7:0]  corr4;
  logic [7:0] row8;  logic [2:0] idx8;  logic rdy8, vld8, last8;  logic [15:0] corr8;

  bw_pp_sequencer #(.WIDTH(4)) u_dut4 (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .a_in          (drv_a[3:0]),
    .b_in          (drv_b[3:0]),
    .in_valid_in   (drv_valid && sel == 0),
    .in_ready_out  (rdy4),
    .row_out       (row4),
    .row_idx_out   (idx4),
    .row_last_out  (last4),
    .row_valid_out (vld4),
    .row_ready_in  (drv_rrdy && sel == 0),
    .corr_out      (corr4)
  );

  bw_pp_sequencer #(.WIDTH(8)) u_dut8 (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .a_in          (drv_a[7:0]),
    .b_in          (drv_b[7:0]),
    .in_valid_in   (drv_valid && sel == 1),
    .in_ready_out  (rdy8),
    .row_out       (row8),
    .row_idx_out   (idx8),
    .row_last_out  (last8),
    .row_valid_out (vld8),
    .row_ready_in  (drv_rrdy && sel == 1),
    .corr_out      (corr8)
  );

  logic        obs_ready, obs_valid, obs_last;
  logic [63:0] obs_row, obs_idx, obs_corr;
  always_comb begin
    obs_ready = rdy4;  obs_valid = vld4;  obs_last = last4;
    obs_row = 64'(row4);  obs_idx = 64'(idx4);  obs_corr = 64'(corr4);
    if (sel == 1) begin
      obs_ready = rdy8;  obs_valid = vld8;  obs_last = last8;
      obs_row = 64'(row8);  obs_idx = 64'(idx8);  obs_corr = 64'(corr8);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Row i bit j is A[j]&B[i], inverted when exactly one of i, j is the sign position.
  function automatic logic [63:0] ref_row(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input int i);
    logic [63:0] r = '0;
    for (int j = 0; j < w; j++) begin
      logic t = a[j] & b[i];
      if ((i == w - 1) != (j == w - 1)) t = ~t;
      r[j] = t;
    end
    return r;
  endfunction

  function automatic longint sext(input logic [63:0] v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(1) <<< w);
    return longint'(v);
  endfunction

  function automatic logic [63:0] pmask(input int w);
    if (w >= 32) return '1;
    return (64'd1 << (2 * w)) - 64'd1;
  endfunction

  logic [63:0] got_rows [32];
  logic [63:0] last_sum;

  // Starts at the falling edge of the first EMIT cycle. bp: 0 ready always,
  // 1 random ready, 2 ready low for 3 cycles while row 1 is offered.
  task automatic collect(input int w, input logic [63:0] a, input logic [63:0] b, input int bp);
    int k = 0;
    int stall = 0;
    int iter = 0;
    logic [63:0] sum = '0;
    logic r;
    while (k < w && iter < 200) begin
      check("row_valid", 64'(obs_valid), 64'd1);
      check("row", obs_row, ref_row(w, a, b, k));
      check("row_idx", obs_idx, 64'(k));
      check("row_last", 64'(obs_last), 64'(k == w - 1));
      got_rows[k] = obs_row;
      case (bp)
        1:       r = (iter > 40) ? 1'b1 : 1'($urandom_range(0, 1));
        2:       if (k == 1 && stall < 3) begin r = 1'b0; stall++; end else r = 1'b1;
        default: r = 1'b1;
      endcase
      drv_rrdy = r;
      if (r) begin
        sum = sum + (obs_row << k);
        k++;
      end
      iter++;
      @(negedge clk);
    end
    check("row_budget", 64'(k), 64'(w));
    drv_rrdy = 1'b0;
    check("idle_ready", 64'(obs_ready), 64'd1);
    check("idle_valid", 64'(obs_valid), 64'd0);
    check("idle_row", obs_row, 64'd0);
    check("idle_idx", obs_idx, 64'd0);
    check("idle_last", 64'(obs_last), 64'd0);
    last_sum = (sum + obs_corr) & pmask(w);
    check("identity", last_sum, 64'(sext(a, w) * sext(b, w)) & pmask(w));
  endtask

  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b, input int bp);
    int t = 0;
    while (!obs_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready", 64'(obs_ready), 64'd1);
    drv_a = a;  drv_b = b;  drv_valid = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;
    drv_a = {$urandom, $urandom};
    drv_b = {$urandom, $urandom};
    collect(w, a, b, bp);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] mix_exp [4] = '{64'h5, 64'h8, 64'h5, 64'h7};
    logic [63:0] neg_exp [4] = '{64'h8, 64'h8, 64'h8, 64'hF};
    int t1, t2;

    rst_n = 1'b0;  sel = 0;  drv_a = '0;  drv_b = '0;  drv_valid = 1'b0;  drv_rrdy = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check("rst_ready", 64'(obs_ready), 64'd1);
      check("rst_valid", 64'(obs_valid), 64'd0);
      check("rst_row", obs_row, 64'd0);
      check("rst_idx", obs_idx, 64'd0);
      check("rst_last", 64'(obs_last), 64'd0);
      check("rst_corr", obs_corr, (s == 0) ? 64'h90 : 64'h8100);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Mixed signs: -3 * 5
    run_op(4, 64'hD, 64'h5, 0);
    for (int i = 0; i < 4; i++) check("mixed_row", got_rows[i], mix_exp[i]);
    check("mixed_sum", last_sum, 64'hF1);

    // Both most negative: -8 * -8
    run_op(4, 64'h8, 64'h8, 0);
    for (int i = 0; i < 4; i++) check("neg_row", got_rows[i], neg_exp[i]);
    check("neg_sum", last_sum, 64'h40);

    // Backpressure on row 1
    run_op(4, 64'hD, 64'h5, 2);
    for (int i = 0; i < 4; i++) check("bp_row", got_rows[i], mix_exp[i]);

    // Back-to-back with in_valid_in held high; second pair sits on the bus during EMIT
    drv_a = 64'h6;  drv_b = 64'hB;  drv_valid = 1'b1;
    @(negedge clk);
    t1 = cyc;
    drv_a = 64'h9;  drv_b = 64'h3;
    collect(4, 64'h6, 64'hB, 0);
    @(negedge clk);
    t2 = cyc;
    drv_valid = 1'b0;
    check("b2b_gap", 64'(t2 - t1), 64'd5);
    collect(4, 64'h9, 64'h3, 0);

    // Reset during row 2
    drv_a = 64'h7;  drv_b = 64'hE;  drv_valid = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;  drv_rrdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mr_idx", obs_idx, 64'd2);
    rst_n = 1'b0;
    #1;
    check("mr_valid", 64'(obs_valid), 64'd0);
    check("mr_ready", 64'(obs_ready), 64'd1);
    check("mr_row", obs_row, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr_idle_valid", 64'(obs_valid), 64'd0);
      check("mr_idle_ready", 64'(obs_ready), 64'd1);
    end
    drv_rrdy = 1'b0;

    // Randomized WIDTH=8 operands with random backpressure
    sel = 1;
    @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      run_op(8, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bw_pp_sequencer.md
# bw_pp_sequencer

Sequential partial-product front end for the Baugh-Wooley signed multiplier. It accepts one pair of two's-complement operands through a valid/ready handshake and emits the WIDTH Baugh-Wooley partial-product rows one per handshake, row index ascending. The complemented sign terms are already applied to each row. The downstream full-adder row/accumulator consumes these rows. It shifts row i left by i and adds the constant correction term to form the 2·WIDTH-bit product modulo 2^(2·WIDTH).

## Interface
- WIDTH, 8, operand width in bits; legal values are 2 to 32.
- IDXW, $clog2(WIDTH), width of the row index; derived, not overridden.
- clk_in  input  1  single clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- a_in  input  WIDTH  multiplicand, signed.
- b_in  input  WIDTH  multiplier, signed.
- in_valid_in  input  1  operand pair valid.
- in_ready_out  output  1  sequencer can accept an operand pair.
- row_out  output  WIDTH  current partial-product row, unweighted.
- row_idx_out  output  IDXW  index i of the current row (weight 2^i).
- row_last_out  output  1  current row is row WIDTH-1.
- row_valid_out  output  1  row_out, row_idx_out and row_last_out are valid.
- row_ready_in  input  1  downstream accepts the row.
- corr_out  output  2·WIDTH  constant correction, 2^WIDTH + 2^(2·WIDTH-1).

## Operation
- FSM states:
  - IDLE: in_ready_out=1, row_valid_out=0.
  - EMIT: in_ready_out=0, row_valid_out=1.
- IDLE → EMIT when in_valid_in && in_ready_out. a_in and b_in are captured into internal registers A and B, and the row counter i is cleared to 0.
- In EMIT, when row_valid_out && row_ready_in:
  - if i < WIDTH-1, i increments;
  - if i == WIDTH-1, the FSM returns to IDLE.
- In EMIT, row_ready_in low holds the state: row, index and last flag stay stable.
- Row i, with N = WIDTH:
  - for i < N-1: bit j (j < N-1) = A[j] & B[i]; bit N-1 = ~(A[N-1] & B[i]).
  - for i = N-1: bit j (j < N-1) = ~(A[j] & B[N-1]); bit N-1 = A[N-1] & B[N-1].
- row_last_out = (i == WIDTH-1) while in EMIT.
- row_out, row_idx_out and row_last_out are forced to 0 whenever row_valid_out is 0.
- in_valid_in is ignored in EMIT. The upstream holds its operands until in_ready_out rises.
- corr_out is a constant, independent of state and reset.
- Reference identity, checked by the bench: Σ (row_i << i) + corr_out ≡ A·B (signed), mod 2^(2·WIDTH).

## Timing
- Reset values: FSM IDLE, in_ready_out=1, row_valid_out=0, row_out=0, row_idx_out=0, row_last_out=0, A=B=0.
- Latency: operand accepted at edge k, row 0 valid in cycle k+1.
- Throughput: with row_ready_in held high, rows 0..WIDTH-1 appear in cycles k+1..k+WIDTH.
- Return to IDLE: in_ready_out is high in cycle k+WIDTH+1. The next operand pair is accepted at the end of that cycle, giving one bubble cycle between operations (WIDTH+1 cycles per multiply).
- Outputs depend only on registered state; there is no combinational path from any input to any output.
- Reset mid-operation: asserting rst_n_in low at any point drops row_valid_out immediately and discards the operation. After release the sequencer is in IDLE; no partial row is re-emitted.
- row_ready_in toggling: each rising edge with valid && ready advances exactly one row. No row is skipped or duplicated.

## Structure
- Package bw_pkg holds:
  - the state enum (IDLE, EMIT);
  - a function bw_corr(width) returning the correction constant;
  - the default WIDTH constant, shared with the adder array.
- Sub-module bw_pp_row (combinational): inputs A, B and row index; output is one Baugh-Wooley row, including the sign-row complement rules.
- bw_pp_sequencer holds:
  - the operand registers;
  - the row counter;
  - the FSM;
  - the output gating.

## Test plan
- Reset: hold rst_n_in low → in_ready_out=1, row_valid_out=0, all row outputs 0; corr_out=0x90 for WIDTH=4.
- Mixed signs: WIDTH=4, A=-3 (0xD), B=5 (0x5), row_ready_in held high → rows 0x5, 0x8, 0x5, 0x7 with indices 0..3, row_last_out only on index 3. Weighted sum 97 + corr 144 = 0xF1 (-15).
- Both most negative: WIDTH=4, A=B=-8 → rows 0x8, 0x8, 0x8, 0xF. Weighted sum plus corr = 0x40 (64).
- Backpressure: same operands as the mixed-signs case, row_ready_in low for 3 cycles at row 1 → row 0x8 / index 1 held stable. After release the sequence resumes with 0x5, then 0x7, with no duplicates.
- Back-to-back: in_valid_in held high with two operand pairs → second pair accepted exactly WIDTH+1 cycles after the first. in_valid_in in EMIT does not corrupt A or B.
- Mid-operation reset, then random: rst_n_in pulsed low during row 2 → row_valid_out drops immediately, then IDLE. Then 1000 random WIDTH=8 pairs with random backpressure → reference identity holds for every product.
